alu_multicycle: RTL

Parametrised multi-cycle ALU for the EX stage of the pipelined CPU. Extends the combinational ALU with configurable datapath width, three more operations, a registered result with Zero/Overflow flags, and an iterative shift-add multiplier. A valid/ready handshake lets the hazard unit stall the pipeline while a multiply is in progress.

---
 rtl/alu_multicycle_if.sv | 24 ++
 rtl/alu_multicycle.sv | 131 +++++++++++++
 2 files changed

// File: rtl/alu_multicycle_if.sv
// Request/result bundle between the EX-stage requester and the multi-cycle ALU.
interface alu_multicycle_if #(
   parameter int unsigned WIDTH = 32
);
   logic             valid_i;
   logic             ready_o;
   logic [WIDTH-1:0] data1_i;
   logic [WIDTH-1:0] data2_i;
   logic [2:0]       ALUCtrl_i;
   logic [WIDTH-1:0] data_o;
   logic             Zero_o;
   logic             Overflow_o;
   logic             done_o;

   modport master (
      output valid_i, data1_i, data2_i, ALUCtrl_i,
      input  ready_o, data_o, Zero_o, Overflow_o, done_o
   );

   modport slave (
      input  valid_i, data1_i, data2_i, ALUCtrl_i,
      output ready_o, data_o, Zero_o, Overflow_o, done_o
   );
endinterface

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle add/sub/logic/compare with registered result
// and flags, plus an iterative shift-add multiplier that holds ready_o low
// for WIDTH cycles while it runs.
module alu_multicycle #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   alu_multicycle_if.slave  bus
);
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   typedef enum logic {
      S_IDLE,
      S_MUL
   } state_t;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_OR   = 3'b011,
      OP_MUL  = 3'b100,
      OP_XOR  = 3'b101,
      OP_SLT  = 3'b110,
      OP_SLTU = 3'b111
   } op_t;

   state_t           state;
   op_t              op;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;
   logic [CNT_W-1:0] cnt;

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] alu_res;
   logic             alu_ovf;
   logic [WIDTH-1:0] acc_sum;
   logic [CNT_W-1:0] cnt_inc;

   // Single-cycle operation result and signed-overflow flag.
   always_comb begin
      op      = op_t'(bus.ALUCtrl_i);
      sum     = bus.data1_i + bus.data2_i;
      diff    = bus.data1_i - bus.data2_i;
      alu_res = '0;
      alu_ovf = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res = sum;
            alu_ovf = (bus.data1_i[WIDTH-1] == bus.data2_i[WIDTH-1]) &&
                      (sum[WIDTH-1] != bus.data1_i[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff;
            alu_ovf = (bus.data1_i[WIDTH-1] != bus.data2_i[WIDTH-1]) &&
                      (diff[WIDTH-1] != bus.data1_i[WIDTH-1]);
         end
         OP_AND:  alu_res = bus.data1_i & bus.data2_i;
         OP_OR:   alu_res = bus.data1_i | bus.data2_i;
         OP_XOR:  alu_res = bus.data1_i ^ bus.data2_i;
         OP_SLT:  alu_res[0] = $signed(bus.data1_i) < $signed(bus.data2_i);
         OP_SLTU: alu_res[0] = bus.data1_i < bus.data2_i;
         default: alu_res = '0;
      endcase
   end

   // Next shift-add step: conditional add of the shifted multiplicand.
   always_comb begin
      acc_sum = acc + (mplier[0] ? mcand : '0);
      cnt_inc = cnt + CNT_W'(1);
   end

   // Control FSM with registered result, flags, handshake and done pulse.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state          <= S_IDLE;
         bus.ready_o    <= 1'b1;
         bus.data_o     <= '0;
         bus.Zero_o     <= 1'b0;
         bus.Overflow_o <= 1'b0;
         bus.done_o     <= 1'b0;
         mcand          <= '0;
         mplier         <= '0;
         acc            <= '0;
         cnt            <= '0;
      end else begin
         bus.done_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.valid_i && bus.ready_o) begin
                  if (op == OP_MUL) begin
                     mcand       <= bus.data1_i;
                     mplier      <= bus.data2_i;
                     acc         <= '0;
                     cnt         <= '0;
                     state       <= S_MUL;
                     bus.ready_o <= 1'b0;
                  end else begin
                     bus.data_o     <= alu_res;
                     bus.Zero_o     <= (alu_res == '0);
                     bus.Overflow_o <= alu_ovf;
                     bus.done_o     <= 1'b1;
                  end
               end
            end
            S_MUL: begin
               acc    <= acc_sum;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt_inc;
               // The last iteration's add is folded straight into data_o.
               if (cnt_inc == CNT_W'(WIDTH)) begin
                  bus.data_o     <= acc_sum;
                  bus.Zero_o     <= (acc_sum == '0);
                  bus.Overflow_o <= 1'b0;
                  bus.done_o     <= 1'b1;
                  bus.ready_o    <= 1'b1;
                  state          <= S_IDLE;
               end
            end
            default: begin
               state       <= S_IDLE;
               bus.ready_o <= 1'b1;
            end
         endcase
      end
   end
endmodule
